// File: rtl/if_fetch_stage.sv
// Instruction-fetch front end: owns the PC, runs the imem req/ack handshake and
// drives the IF/ID register, with a one-entry skid buffer and branch redirect.
module if_fetch_stage #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter logic [31:0] NOP      = 32'h0000_0013
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   output logic        imem_req_o,
   output logic [63:0] imem_addr_o,
   input  logic        imem_ack_i,
   input  logic [31:0] imem_rdata_i,
   input  logic        stall_i,
   input  logic        redirect_valid_i,
   input  logic [63:0] redirect_pc_i,
   output logic        if_id_valid_o,
   output logic [63:0] if_id_pc_o,
   output logic [31:0] if_id_inst_o
);

   localparam logic [1:0] FETCH = 2'd0;
   localparam logic [1:0] SKID  = 2'd1;
   localparam logic [1:0] DRAIN = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic [63:0] req_addr_q, req_addr_d;
   logic        skid_vld_q, skid_vld_d;
   logic [63:0] skid_pc_q, skid_pc_d;
   logic [31:0] skid_inst_q, skid_inst_d;
   logic        ifid_vld_q, ifid_vld_d;
   logic [63:0] ifid_pc_q, ifid_pc_d;
   logic [31:0] ifid_inst_q, ifid_inst_d;

   // Request decoded from state only, so there is no input-to-output path.
   assign imem_req_o  = (state_q != SKID);
   assign imem_addr_o = (state_q == DRAIN) ? req_addr_q : pc_q;

   assign if_id_valid_o = ifid_vld_q;
   assign if_id_pc_o    = ifid_pc_q;
   assign if_id_inst_o  = ifid_inst_q;

   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      req_addr_d  = req_addr_q;
      skid_vld_d  = skid_vld_q;
      skid_pc_d   = skid_pc_q;
      skid_inst_d = skid_inst_q;
      ifid_vld_d  = ifid_vld_q;
      ifid_pc_d   = ifid_pc_q;
      ifid_inst_d = ifid_inst_q;

      if (redirect_valid_i) begin
         // Redirect beats stall and ack; any in-flight data is thrown away.
         pc_d        = redirect_pc_i;
         ifid_vld_d  = 1'b0;
         ifid_pc_d   = 64'h0;
         ifid_inst_d = NOP;
         skid_vld_d  = 1'b0;
         case (state_q)
            FETCH: begin
               if (!imem_ack_i) begin
                  req_addr_d = imem_addr_o;
                  state_d    = DRAIN;
               end
            end
            SKID:    state_d = FETCH;
            DRAIN:   if (imem_ack_i) state_d = FETCH;
            default: state_d = FETCH;
         endcase
      end else begin
         case (state_q)
            FETCH: begin
               if (imem_ack_i) begin
                  pc_d = pc_q + 64'd4;
                  if (stall_i) begin
                     skid_vld_d  = 1'b1;
                     skid_pc_d   = pc_q;
                     skid_inst_d = imem_rdata_i;
                     state_d     = SKID;
                  end else begin
                     ifid_vld_d  = 1'b1;
                     ifid_pc_d   = pc_q;
                     ifid_inst_d = imem_rdata_i;
                  end
               end else if (!stall_i) begin
                  ifid_vld_d = 1'b0;
               end
            end
            SKID: begin
               if (!stall_i) begin
                  ifid_vld_d  = skid_vld_q;
                  ifid_pc_d   = skid_pc_q;
                  ifid_inst_d = skid_inst_q;
                  skid_vld_d  = 1'b0;
                  state_d     = FETCH;
               end
            end
            DRAIN: begin
               if (imem_ack_i) state_d = FETCH;
            end
            default: state_d = FETCH;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= FETCH;
         pc_q        <= RESET_PC;
         req_addr_q  <= 64'h0;
         skid_vld_q  <= 1'b0;
         skid_pc_q   <= 64'h0;
         skid_inst_q <= NOP;
         ifid_vld_q  <= 1'b0;
         ifid_pc_q   <= 64'h0;
         ifid_inst_q <= NOP;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         req_addr_q  <= req_addr_d;
         skid_vld_q  <= skid_vld_d;
         skid_pc_q   <= skid_pc_d;
         skid_inst_q <= skid_inst_d;
         ifid_vld_q  <= ifid_vld_d;
         ifid_pc_q   <= ifid_pc_d;
         ifid_inst_q <= ifid_inst_d;
      end
   end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed scenarios with literal expectations plus a
// long randomized run checked every cycle against a transaction-level model.
module tb_if_fetch_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        imem_req;
   logic [63:0] imem_addr;
   logic        imem_ack = 1'b0;
   logic [31:0] imem_rdata = 32'h0;
   logic        stall = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [63:0] redirect_pc = 64'h0;
   logic        if_id_valid;
   logic [63:0] if_id_pc;
   logic [31:0] if_id_inst;

   int checks = 0;
   int failures = 0;
   int wait_n = 0;
   int cnt = 0;

   // Model: next address to fetch, an instruction parked behind a stall,
   // an abandoned fetch still owed an ack, and the IF/ID contents.
   logic [63:0] m_pc;
   logic        m_held;
   logic [63:0] m_held_pc;
   logic [31:0] m_held_inst;
   logic        m_owed;
   logic [63:0] m_owed_addr;
   logic        m_v;
   logic [63:0] m_ipc;
   logic [31:0] m_inst;

   if_fetch_stage dut (
      .clk_i           (clk),
      .rst_ni          (rst_n),
      .imem_req_o      (imem_req),
      .imem_addr_o     (imem_addr),
      .imem_ack_i      (imem_ack),
      .imem_rdata_i    (imem_rdata),
      .stall_i         (stall),
      .redirect_valid_i(redirect_valid),
      .redirect_pc_i   (redirect_pc),
      .if_id_valid_o   (if_id_valid),
      .if_id_pc_o      (if_id_pc),
      .if_id_inst_o    (if_id_inst)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] inst_of(input logic [63:0] a);
      return {a[31:2], 2'b11};
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_pc = 64'h0; m_held = 1'b0; m_held_pc = 64'h0; m_held_inst = NOP;
      m_owed = 1'b0; m_owed_addr = 64'h0;
      m_v = 1'b0; m_ipc = 64'h0; m_inst = NOP;
   endtask

   task automatic model_step(input logic ack, input logic [31:0] rd, input logic st,
                             input logic rv, input logic [63:0] rp);
      if (rv) begin
         if (!m_held && !m_owed && !ack) begin
            m_owed = 1'b1;
            m_owed_addr = m_pc;
         end else if (m_owed && ack) begin
            m_owed = 1'b0;
         end
         m_held = 1'b0;
         m_pc = rp;
         m_v = 1'b0; m_ipc = 64'h0; m_inst = NOP;
      end else if (m_held) begin
         if (!st) begin
            m_v = 1'b1; m_ipc = m_held_pc; m_inst = m_held_inst;
            m_held = 1'b0;
         end
      end else if (m_owed) begin
         if (ack) m_owed = 1'b0;
      end else if (ack) begin
         if (st) begin
            m_held = 1'b1; m_held_pc = m_pc; m_held_inst = rd;
         end else begin
            m_v = 1'b1; m_ipc = m_pc; m_inst = rd;
         end
         m_pc = m_pc + 64'd4;
      end else if (!st) begin
         m_v = 1'b0;
      end
   endtask

   task automatic compare_model();
      check("mdl_valid", {63'h0, if_id_valid}, {63'h0, m_v});
      check("mdl_pc", if_id_pc, m_ipc);
      check("mdl_inst", {32'h0, if_id_inst}, {32'h0, m_inst});
      check("mdl_req", {63'h0, imem_req}, {63'h0, !m_held});
      if (!m_held) check("mdl_addr", imem_addr, m_owed ? m_owed_addr : m_pc);
   endtask

   // Called at posedge+1; returns at the next posedge+1 after checking the model.
   task automatic tick(input logic st, input logic rv, input logic [63:0] rp);
      logic ack;
      int nxt;
      ack = imem_req && (cnt >= wait_n);
      imem_ack = ack;
      imem_rdata = inst_of(imem_addr);
      stall = st;
      redirect_valid = rv;
      redirect_pc = rp;
      nxt = ack ? 0 : (imem_req ? cnt + 1 : 0);
      model_step(ack, imem_rdata, st, rv, rp);
      @(posedge clk);
      cnt = nxt;
      #1;
      imem_ack = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      compare_model();
   endtask

   // Called at posedge+1; asserts reset asynchronously and checks outputs at once.
   task automatic do_reset();
      rst_n = 1'b0;
      imem_ack = 1'b0;
      stall = 1'b0;
      redirect_valid = 1'b0;
      #1;
      check("rst_valid", {63'h0, if_id_valid}, 64'h0);
      check("rst_pc", if_id_pc, 64'h0);
      check("rst_inst", {32'h0, if_id_inst}, {32'h0, NOP});
      check("rst_req", {63'h0, imem_req}, 64'h1);
      check("rst_addr", imem_addr, 64'h0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cnt = 0;
      model_reset();
   endtask

   initial begin
      model_reset();
      @(posedge clk);
      #1;

      // Zero-wait streaming from reset.
      do_reset();
      wait_n = 0;
      for (int i = 0; i < 4; i++) begin
         check("zw_addr", imem_addr, 64'(4 * i));
         tick(1'b0, 1'b0, 64'h0);
         check("zw_valid", {63'h0, if_id_valid}, 64'h1);
         check("zw_pc", if_id_pc, 64'(4 * i));
      end
      check("zw_inst0_lit", 64'(inst_of(64'h8)), 64'h0000_000B);

      // Two wait cycles: each instruction followed by two bubbles.
      do_reset();
      wait_n = 2;
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      for (int k = 0; k < 3; k++) begin
         check("w2_valid", {63'h0, if_id_valid}, 64'h1);
         check("w2_pc", if_id_pc, 64'(4 * k));
         tick(1'b0, 1'b0, 64'h0);
         check("w2_bubble1", {63'h0, if_id_valid}, 64'h0);
         tick(1'b0, 1'b0, 64'h0);
         check("w2_bubble2", {63'h0, if_id_valid}, 64'h0);
         tick(1'b0, 1'b0, 64'h0);
      end

      // Stall raised together with the ack at pc=8.
      do_reset();
      wait_n = 0;
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      check("st_addr8", imem_addr, 64'h8);
      for (int k = 0; k < 3; k++) begin
         tick(1'b1, 1'b0, 64'h0);
         check("st_hold_pc", if_id_pc, 64'h4);
         check("st_hold_v", {63'h0, if_id_valid}, 64'h1);
      end
      tick(1'b0, 1'b0, 64'h0);
      check("st_skid_pc", if_id_pc, 64'h8);
      check("st_skid_inst", {32'h0, if_id_inst}, 64'h0000_000B);
      tick(1'b0, 1'b0, 64'h0);
      check("st_next_pc", if_id_pc, 64'hC);

      // Redirect while a fetch of 0x20 is outstanding with two wait cycles.
      do_reset();
      wait_n = 0;
      tick(1'b0, 1'b1, 64'h20);
      wait_n = 2;
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b1, 64'h100);
      check("rd_flush_v", {63'h0, if_id_valid}, 64'h0);
      check("rd_flush_inst", {32'h0, if_id_inst}, {32'h0, NOP});
      check("rd_old_addr", imem_addr, 64'h20);
      tick(1'b0, 1'b0, 64'h0);
      check("rd_new_addr", imem_addr, 64'h100);
      check("rd_discard", {63'h0, if_id_valid}, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      tick(1'b0, 1'b0, 64'h0);
      check("rd_tgt_v", {63'h0, if_id_valid}, 64'h1);
      check("rd_tgt_pc", if_id_pc, 64'h100);
      check("rd_tgt_inst", {32'h0, if_id_inst}, 64'h0000_0103);

      // Redirect and stall together with an ack: redirect wins.
      wait_n = 0;
      tick(1'b1, 1'b1, 64'h200);
      check("rs_flush_v", {63'h0, if_id_valid}, 64'h0);
      check("rs_flush_inst", {32'h0, if_id_inst}, {32'h0, NOP});
      check("rs_addr", imem_addr, 64'h200);
      tick(1'b0, 1'b0, 64'h0);
      check("rs_tgt_pc", if_id_pc, 64'h200);
      check("rs_tgt_v", {63'h0, if_id_valid}, 64'h1);

      // Reset asserted mid-DRAIN.
      wait_n = 0;
      tick(1'b0, 1'b1, 64'h40);
      wait_n = 3;
      tick(1'b0, 1'b1, 64'h300);
      check("rm_drain_addr", imem_addr, 64'h40);
      do_reset();
      check("rm_first_addr", imem_addr, 64'h0);
      tick(1'b0, 1'b0, 64'h0);

      // PC wrap at the top of the address space.
      do_reset();
      wait_n = 0;
      tick(1'b0, 1'b1, 64'hFFFF_FFFF_FFFF_FFFC);
      check("wr_addr_top", imem_addr, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(1'b0, 1'b0, 64'h0);
      check("wr_addr_wrap", imem_addr, 64'h0);
      check("wr_pc", if_id_pc, 64'hFFFF_FFFF_FFFF_FFFC);
      tick(1'b0, 1'b0, 64'h0);
      check("wr_pc0", if_id_pc, 64'h0);

      // Randomized run against the model.
      for (int n = 0; n < 3000; n++) begin
         logic st, rv;
         logic [63:0] rp;
         if (n % 200 == 0) wait_n = $urandom_range(0, 3);
         if ($urandom_range(0, 499) == 0) begin
            do_reset();
         end else begin
            st = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 19) == 0);
            rp = ($urandom_range(0, 7) == 0) ? 64'hFFFF_FFFF_FFFF_FFF8
                                             : ({$urandom, $urandom} & ~64'h3);
            tick(st, rv, rp);
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
